// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_boot_loader.
//   byte_valid/byte_data/byte_ready : incoming boot stream handshake
//   imem_we/imem_addr/imem_wdata    : one-cycle word write into instruction memory
//   cpu_hold/load_done/load_error   : pipeline stall and sticky load status
interface imem_boot_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;

   // stream source / status consumer
   modport master (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
   );

   // the loader itself
   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader: takes a byte stream (16-bit word count,
// big-endian 32-bit words, XOR checksum byte), writes each word into
// instruction memory and holds the CPU until the image is verified.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : imem_boot_loader_if.slave (stream in, imem write out, status out)
module imem_boot_loader #(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic               clk,
   input logic               reset,
   imem_boot_loader_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR
   } state_t;

   state_t             state_q;
   logic [15:0]        count_q;
   logic [IDX_W-1:0]   word_idx;
   logic [1:0]         byte_idx;
   logic [23:0]        asm_q;
   logic [7:0]         xor_q;

   logic               acc;
   logic [15:0]        cnt_w;
   logic               last_word;

   assign acc       = bus.byte_valid && bus.byte_ready;
   // full count as it will be once the low byte lands
   assign cnt_w     = {count_q[15:8], bus.byte_data};
   assign last_word = (16'(word_idx) + 16'd1) == count_q;

   // stream FSM with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= CNT_HI;
         count_q        <= '0;
         word_idx       <= '0;
         byte_idx       <= '0;
         asm_q          <= '0;
         xor_q          <= '0;
         bus.byte_ready <= 1'b1;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= BASE_ADDR;
         bus.imem_wdata <= '0;
         bus.cpu_hold   <= 1'b1;
         bus.load_done  <= 1'b0;
         bus.load_error <= 1'b0;
      end else begin
         bus.imem_we <= 1'b0;
         case (state_q)
            CNT_HI: begin
               if (acc) begin
                  count_q[15:8] <= bus.byte_data;
                  xor_q         <= xor_q ^ bus.byte_data;
                  state_q       <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (acc) begin
                  count_q[7:0] <= bus.byte_data;
                  xor_q        <= xor_q ^ bus.byte_data;
                  if (cnt_w > 16'(DEPTH)) begin
                     state_q        <= ERR;
                     bus.byte_ready <= 1'b0;
                     bus.load_error <= 1'b1;
                  end else if (cnt_w == 16'd0) begin
                     state_q <= CHECK;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (acc) begin
                  xor_q <= xor_q ^ bus.byte_data;
                  if (byte_idx == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_wdata <= {asm_q, bus.byte_data};
                     bus.imem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
                     word_idx       <= word_idx + IDX_W'(1);
                     byte_idx       <= 2'd0;
                     if (last_word) begin
                        state_q <= CHECK;
                     end
                  end else begin
                     asm_q    <= {asm_q[15:0], bus.byte_data};
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            CHECK: begin
               if (acc) begin
                  bus.byte_ready <= 1'b0;
                  if (bus.byte_data == xor_q) begin
                     state_q       <= DONE;
                     bus.cpu_hold  <= 1'b0;
                     bus.load_done <= 1'b1;
                  end else begin
                     state_q        <= ERR;
                     bus.load_error <= 1'b1;
                  end
               end
            end
            DONE: begin
            end
            ERR: begin
            end
            default: begin
               // unused encodings fail safe: stall and flag
               state_q        <= ERR;
               bus.byte_ready <= 1'b0;
               bus.cpu_hold   <= 1'b1;
               bus.load_done  <= 1'b0;
               bus.load_error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every imem_we pulse.
module tb_imem_boot_loader;

   logic clk = 1'b0;
   logic reset;

   imem_boot_loader_if bif ();

   imem_boot_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mon_checks = 0;
   int mon_errors = 0;

   logic [63:0] exp_q [$];

   logic [7:0] stream [0:15];
   int         slen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // write monitor
   always @(negedge clk) begin
      if (bif.imem_we === 1'b1) begin
         mon_checks++;
         if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     bif.imem_addr, bif.imem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({bif.imem_addr, bif.imem_wdata} !== e) begin
               mon_errors++;
               $display("FAIL write: got addr %h data %h expected addr %h data %h",
                        bif.imem_addr, bif.imem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   // one accepted byte: drive for one edge, then drop valid
   task automatic send(input logic [7:0] b);
      check("byte_ready_before_send", 32'(bif.byte_ready), 32'd1);
      bif.byte_valid = 1'b1;
      bif.byte_data  = b;
      @(posedge clk);
      #1;
      bif.byte_valid = 1'b0;
      bif.byte_data  = 8'hxx;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bif.byte_valid = 1'b0;
      bif.byte_data  = 8'h00;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic load_normal();
      stream[0] = 8'h00; stream[1] = 8'h02;
      stream[2] = 8'h20; stream[3] = 8'h10; stream[4] = 8'h00; stream[5] = 8'h05;
      stream[6] = 8'h02; stream[7] = 8'h32; stream[8] = 8'h80; stream[9] = 8'h20;
      stream[10] = 8'hA7;
      slen = 11;
   endtask

   task automatic play(input int first, input int last, input bit gaps);
      for (int i = first; i <= last; i++) begin
         send(stream[i]);
         if (gaps) begin
            int n;
            n = $urandom_range(0, 3);
            repeat (n) begin
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic push_normal_writes();
      exp_q.push_back({32'h0000_0000, 32'h2010_0005});
      exp_q.push_back({32'h0000_0004, 32'h0232_8020});
   endtask

   task automatic check_final(input string tag, input logic done, input logic err);
      @(negedge clk);
      check({tag, "_load_done"},  32'(bif.load_done),  32'(done));
      check({tag, "_load_error"}, 32'(bif.load_error), 32'(err));
      check({tag, "_cpu_hold"},   32'(bif.cpu_hold),   32'(!done));
      check({tag, "_byte_ready"}, 32'(bif.byte_ready), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_byte_ready"}, 32'(bif.byte_ready), 32'd1);
      check({tag, "_imem_we"},    32'(bif.imem_we),    32'd0);
      check({tag, "_imem_addr"},  bif.imem_addr,       32'h0000_0000);
      check({tag, "_imem_wdata"}, bif.imem_wdata,      32'h0000_0000);
      check({tag, "_cpu_hold"},   32'(bif.cpu_hold),   32'd1);
      check({tag, "_load_done"},  32'(bif.load_done),  32'd0);
      check({tag, "_load_error"}, 32'(bif.load_error), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bif.byte_valid = 1'b0;
      bif.byte_data  = 8'h00;
      #1;
      check_reset_vals("reset");
      do_reset();

      // normal load
      load_normal();
      push_normal_writes();
      play(0, slen - 1, 1'b0);
      check_final("normal", 1'b1, 1'b0);

      // zero count
      do_reset();
      stream[0] = 8'h00; stream[1] = 8'h00; stream[2] = 8'h00; slen = 3;
      play(0, slen - 1, 1'b0);
      check_final("zero", 1'b1, 1'b0);

      // bad checksum: writes still land
      do_reset();
      load_normal();
      stream[10] = 8'hA6;
      push_normal_writes();
      play(0, slen - 1, 1'b0);
      check_final("badsum", 1'b0, 1'b1);

      // count overflow (65 > 64)
      do_reset();
      stream[0] = 8'h00; stream[1] = 8'h41; slen = 2;
      play(0, slen - 1, 1'b0);
      check_final("overflow", 1'b0, 1'b1);

      // gapped valid
      do_reset();
      load_normal();
      push_normal_writes();
      play(0, slen - 1, 1'b1);
      check_final("gapped", 1'b1, 1'b0);

      // reset after 5 bytes, then full replay
      do_reset();
      load_normal();
      play(0, 4, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("midreset5");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      push_normal_writes();
      play(0, slen - 1, 1'b0);
      check_final("replay5", 1'b1, 1'b0);

      // reset while a write strobe is pending: strobe and word discarded
      do_reset();
      load_normal();
      play(0, 5, 1'b0);
      check("pending_we", 32'(bif.imem_we), 32'd1);
      check("pending_wdata", bif.imem_wdata, 32'h2010_0005);
      reset = 1'b1;
      #1;
      check_reset_vals("midreset6");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      push_normal_writes();
      play(0, slen - 1, 1'b0);
      check_final("replay6", 1'b1, 1'b0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors + mon_errors, checks + mon_checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer side of the instruction memory. The pipeline fetches from instruction memory; this block fills it before the CPU runs.
- Accepts a byte stream (word count, instruction words, checksum) and assembles big-endian 32-bit words.
- Issues one write per word into instruction memory.
- Holds the pipeline stalled until the image is fully loaded and verified.

Parameters:
- DEPTH, 64, instruction memory capacity in 32-bit words (max loadable count)
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word aligned)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- byte_valid  input  1  byte_data holds a valid stream byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  32  byte address of the write
- imem_wdata  output  32  instruction word to write
- cpu_hold  output  1  keep pipeline PC/registers frozen while high
- load_done  output  1  sticky, image loaded and checksum matched
- load_error  output  1  sticky, count overflow or checksum mismatch

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=CNT_HI, byte_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0. Internal count, word index, byte index and running XOR are all 0.
- Handshake: a byte is accepted on an edge where byte_valid && byte_ready. byte_valid low is a stall with no state change. byte_data is don't-care when not accepted.
- Stream format: count[15:8], count[7:0], then count words of 4 bytes each (MSB first), then one checksum byte.
- Checksum rule: the checksum byte equals the XOR of every preceding stream byte, count bytes included.
- States and transitions:
  - CNT_HI: accept byte into count[15:8] -> CNT_LO.
  - CNT_LO: accept byte into count[7:0]. If count > DEPTH -> ERR. Else if count == 0 -> CHECK. Else -> DATA.
  - DATA: shift accepted byte into the assembly register and advance byte index 0..3. When byte index 3 is accepted:
    - next cycle: imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR + 4*word_index; word index increments.
    - After the last word -> CHECK.
    - byte_ready stays 1 during the write cycle (no bubble).
    - Writes never overlap, since a word needs at least 4 accept cycles.
  - CHECK: accept one byte.
    - Match with running XOR -> DONE: cpu_hold=0 and load_done=1 on the next cycle.
    - Mismatch -> ERR.
  - DONE: byte_ready=0, cpu_hold=0, load_done=1. Terminal until reset.
  - ERR: byte_ready=0, cpu_hold=1, load_error=1. Terminal until reset. Words already written are not rolled back.
- imem_we: a single-cycle pulse. imem_addr and imem_wdata hold their last values when imem_we=0.
- Word index: sized for DEPTH. Address arithmetic is 32-bit and wraps modulo 2^32 (unreachable with legal DEPTH/BASE_ADDR).
- Reset mid-load: all state returns to reset values immediately (asynchronous). A partial word is discarded and a pending write strobe is cancelled.
- load_done and load_error are never both 1.

Test Plan:
- Normal load: stream 00 02 20 10 00 05 02 32 80 20 A7 ->
  - imem_we pulses twice: addr 0x0 data 0x20100005, then addr 0x4 data 0x02328020.
  - After A7 is accepted: load_done=1, cpu_hold=0, byte_ready=0.
- Zero count: stream 00 00 00 -> no imem_we pulse; load_done=1, cpu_hold=0.
- Bad checksum: normal stream with last byte A6 -> both writes still occur; load_error=1, load_done=0, cpu_hold stays 1.
- Overflow with DEPTH=64: stream 00 41 -> ERR after the second byte; byte_ready=0, load_error=1, no writes.
- Gapped valid: normal stream with byte_valid low for 0..3 random cycles between bytes -> identical writes and final flags as the normal-load case.
- Reset mid-load: assert reset after 5 accepted bytes -> outputs return to reset values asynchronously. Replaying the full normal stream then produces exactly the normal-load result.
